grant_decoder_2x4: RTL and testbench

Registered 2-to-4 grant decoder that consumes the encoded index `Y` and valid flag `z` produced by the 4-input priority encoder, and drives a one-hot grant vector back toward the four requesters. It holds each grant until the granted requester signals completion on its `done` line, inserts one guard cycle with no grant, then accepts the next request. Together with the priority encoder it closes a simple 4-requester arbitration loop.

---
 rtl/grant_decoder_2x4_pkg.sv | 18 +
 rtl/grant_decoder_2x4_if.sv | 13 +
 rtl/grant_decoder_2x4_dec.sv | 15 +
 rtl/grant_decoder_2x4.sv | 117 +++++++++++
 tb/tb_grant_decoder_2x4.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_decoder_2x4_pkg.sv
// Shared definitions for the registered 2-to-4 grant decoder:
// state encoding, default maximum hold length, and a counter-width helper.
package grant_decoder_2x4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int HOLD_MAX_DEFAULT = 15;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grant_decoder_2x4_if.sv
// Arbitration-loop bus between the requesters/priority encoder (master)
// and the grant decoder (slave).
interface grant_decoder_2x4_if;
  logic [1:0] Y;     // encoded requester index
  logic       z;     // index valid
  logic [3:0] done;  // per-requester release
  logic [3:0] D;     // one-hot grant
  logic       busy;  // grant or guard cycle in progress
  logic       err;   // forced-release pulse

  modport master (output Y, z, done, input D, busy, err);
  modport slave  (input Y, z, done, output D, busy, err);
endinterface

// File: rtl/grant_decoder_2x4_dec.sv
// Purely combinational 2-to-4 decoder: index plus enable to one-hot.
module decoder_2x4 (
  input  logic [1:0] idx_i,
  input  logic       en_i,
  output logic [3:0] onehot_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (idx_i == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/grant_decoder_2x4.sv
// Registered 2-to-4 grant decoder closing a 4-requester arbitration loop.
// Grants the index presented in IDLE, holds it until done[idx], then spends
// one guard cycle in RELEASE before accepting the next request.
// Optional feature macro: GRANT_TIMEOUT_EN (forced release after HOLD_MAX
// grant cycles, flagged by a one-cycle err pulse).
module grant_decoder_2x4
  import grant_decoder_2x4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  grant_decoder_2x4_if.slave bus
);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] d_q;
  logic [3:0] dec_onehot;
  logic       busy_q;
  logic       err_q, err_d;

`ifdef GRANT_TIMEOUT_EN
  localparam int CW = cnt_width(HOLD_MAX);
  logic [CW-1:0] hold_q, hold_d;
  logic          timeout;

  // Last permitted grant cycle reached without a release.
  assign timeout = (hold_q == CW'(HOLD_MAX - 1));
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX > 0);
`endif

  // Next-state logic: latch the index on request, release on done or timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Y is only looked at when z is high, so an undriven Y never leaks in.
        if (bus.z) begin
          state_d = ST_GRANT;
          idx_d   = bus.Y;
`ifdef GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef GRANT_TIMEOUT_EN
        hold_d = hold_q + CW'(1);
`endif
        // done takes precedence over a coincident timeout.
        if (bus.done[idx_q]) begin
          state_d = ST_RELEASE;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_RELEASE;
          err_d   = 1'b1;
        end
`endif
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // One-hot grant derived from the next state so D is a plain register.
  decoder_2x4 u_dec (
    .idx_i    (idx_d),
    .en_i     (state_d == ST_GRANT),
    .onehot_o (dec_onehot)
  );

  // State, index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      d_q     <= 4'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= dec_onehot;
      busy_q  <= (state_d == ST_GRANT) || (state_d == ST_RELEASE);
      err_q   <= err_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Hold counter: cleared on entry to GRANT, counts grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign bus.D    = d_q;
  assign bus.busy = busy_q;
`ifdef GRANT_TIMEOUT_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_grant_decoder_2x4.sv
// Self-checking bench for grant_decoder_2x4: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_grant_decoder_2x4;

  localparam int HOLD_MAX = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  grant_decoder_2x4_if bus ();

  grant_decoder_2x4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the grant, how long they have had it,
  // and whether the guard cycle is in progress.
  int m_owner = -1;
  int m_age   = 0;
  int m_cool  = 0;
  bit m_err   = 1'b0;

  function automatic logic [3:0] exp_d();
    logic [3:0] v;
    v = 4'd0;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_busy();
    return (m_owner >= 0) || (m_cool > 0);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_age = 0; m_cool = 0; m_err = 1'b0;
    end else if (m_owner >= 0) begin
      m_age = m_age + 1;
      if (bus.done[m_owner]) begin
        m_owner = -1; m_cool = 1; m_err = 1'b0;
      end else if (TO_EN && m_age == HOLD_MAX) begin
        m_owner = -1; m_cool = 1; m_err = 1'b1;
      end else begin
        m_err = 1'b0;
      end
    end else if (m_cool > 0) begin
      m_cool = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (bus.z) begin
        m_owner = int'(bus.Y); m_age = 0;
      end
    end
  endtask

  // Advance one clock: model sees the same inputs the DUT samples,
  // outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic z, input logic [1:0] y, input logic [3:0] dn);
    bus.z = z; bus.Y = y; bus.done = dn;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'd0);
    tick(); tick();
    n_checks++;
    if (bus.D !== 4'd0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: D=%b busy=%b err=%b required D=0000 busy=0 err=0", bus.D, bus.busy, bus.err);
    end
    rst = 1'b0;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_single_grant();
    drive(1'b1, 2'd2, 4'd0);
    tick();
    n_checks++;
    if (bus.D !== 4'b0100 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL grant_y2: D=%b busy=%b required D=0100 busy=1", bus.D, bus.busy);
    end
    drive(1'b0, 2'd0, 4'b0100);
    tick();
    n_checks++;
    if (bus.D !== 4'b0000 || bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL release_y2: D=%b busy=%b err=%b required D=0000 busy=1 err=0", bus.D, bus.busy, bus.err);
    end
    drive(1'b0, 2'd0, 4'd0);
    tick();
    n_checks++;
    if (bus.D !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_release: D=%b busy=%b required D=0000 busy=0", bus.D, bus.busy);
    end
    $display("test_single_grant: done");
  endtask

  task automatic test_ignore_in_grant();
    drive(1'b1, 2'd1, 4'd0);
    tick();
    drive(1'b1, 2'd3, 4'b1000);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.D !== 4'b0010 || bus.busy !== 1'b1 || bus.D !== exp_d()) begin
        n_fail++;
        $display("FAIL hold_ignore[%0d]: D=%b busy=%b required D=0010 busy=1", i, bus.D, bus.busy);
      end
    end
    drive(1'b0, 2'd0, 4'b0010);
    tick();
    n_checks++;
    if (bus.D !== 4'd0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL release_y1: D=%b busy=%b required D=0000 busy=1", bus.D, bus.busy);
    end
    drive(1'b0, 2'd0, 4'd0);
    tick(); tick();
    $display("test_ignore_in_grant: done");
  endtask

  task automatic test_x_idle();
    bus.z = 1'b0; bus.Y = 2'bxx; bus.done = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.D !== 4'd0 || bus.busy !== 1'b0 || bus.err !== 1'b0 ||
          $isunknown({bus.D, bus.busy, bus.err})) begin
        n_fail++;
        $display("FAIL x_idle[%0d]: D=%b busy=%b err=%b required D=0000 busy=0 err=0", i, bus.D, bus.busy, bus.err);
      end
    end
    bus.Y = 2'd0;
    $display("test_x_idle: done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    drive(1'b1, 2'd0, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      tick();
      want = (i % 3 == 0) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (bus.D !== want || bus.D !== exp_d()) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: D=%b required %b", i, bus.D, want);
      end
    end
    drive(1'b0, 2'd0, 4'd0);
    tick(); tick(); tick();
    $display("test_back_to_back: done");
  endtask

  task automatic test_timeout();
    int cnt;
    drive(1'b1, 2'd3, 4'd0);
    tick();
    drive(1'b0, 2'd0, 4'd0);
    cnt = 0;
    for (int i = 0; i < 30 && bus.D === 4'b1000; i++) begin
      cnt++;
      if (bus.err !== 1'b0) begin
        n_checks++; n_fail++;
        $display("FAIL err_during_grant: err=%b required 0", bus.err);
      end
      tick();
    end
`ifdef GRANT_TIMEOUT_EN
    n_checks++;
    if (cnt != HOLD_MAX) begin
      n_fail++;
      $display("FAIL timeout_len: grant cycles=%0d required %0d", cnt, HOLD_MAX);
    end
    n_checks++;
    if (bus.err !== 1'b1 || bus.D !== 4'd0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b D=%b busy=%b required err=1 D=0000 busy=1", bus.err, bus.D, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: err=%b busy=%b required err=0 busy=0", bus.err, bus.busy);
    end
    // done[3] arriving in the last permitted grant cycle wins over timeout
    drive(1'b1, 2'd3, 4'd0);
    tick();
    drive(1'b0, 2'd0, 4'd0);
    tick(); tick(); tick();
    drive(1'b0, 2'd0, 4'b1000);
    tick();
    n_checks++;
    if (bus.err !== 1'b0 || bus.D !== 4'd0 || bus.err !== m_err) begin
      n_fail++;
      $display("FAIL done_beats_timeout: err=%b D=%b required err=0 D=0000", bus.err, bus.D);
    end
`else
    n_checks++;
    if (cnt != 30 || bus.D !== 4'b1000) begin
      n_fail++;
      $display("FAIL no_timeout_hold: grant cycles=%0d D=%b required 30 cycles D=1000", cnt, bus.D);
    end
    drive(1'b0, 2'd0, 4'b1000);
    tick();
    n_checks++;
    if (bus.err !== 1'b0 || bus.D !== 4'd0) begin
      n_fail++;
      $display("FAIL no_timeout_release: err=%b D=%b required err=0 D=0000", bus.err, bus.D);
    end
`endif
    drive(1'b0, 2'd0, 4'd0);
    tick(); tick();
    $display("test_timeout: done");
  endtask

  task automatic test_reset_mid_grant();
    drive(1'b1, 2'd2, 4'd0);
    tick();
    drive(1'b0, 2'd0, 4'd0);
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.D !== 4'd0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: D=%b busy=%b err=%b required D=0000 busy=0 err=0", bus.D, bus.busy, bus.err);
    end
    rst = 1'b0;
    drive(1'b1, 2'd1, 4'd0);
    tick();
    n_checks++;
    if (bus.D !== 4'b0010 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL grant_after_reset: D=%b busy=%b required D=0010 busy=1", bus.D, bus.busy);
    end
    drive(1'b0, 2'd0, 4'b0010);
    tick();
    drive(1'b0, 2'd0, 4'd0);
    tick();
    $display("test_reset_mid_grant: done");
  endtask

  task automatic test_random();
    int grants;
    int errs;
    grants = 0; errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      bus.z    = $urandom_range(0, 1);
      bus.Y    = 2'($urandom_range(0, 3));
      bus.done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      tick();
      n_checks++;
      if (bus.D !== exp_d() || bus.busy !== exp_busy() || bus.err !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: D=%b busy=%b err=%b required D=%b busy=%b err=%b",
                 i, bus.D, bus.busy, bus.err, exp_d(), exp_busy(), m_err);
      end
      if (m_owner >= 0 && m_age == 0) grants++;
      if (m_err) errs++;
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 4'd0);
    $display("test_random: %0d grants, %0d forced releases", grants, errs);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'd0);
    test_reset();
    test_single_grant();
    test_ignore_in_grant();
    test_x_idle();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
